ring_osc_i: RTL and testbench
=============================

// Module: ring_osc_i
// PURPOSE
//  Synthesizable, clock-driven model of a gated ring oscillator used as an entropy/PUF source primitive.
//  STAGES inverter stages form a ring. Each stage takes a programmable number of clock cycles to propagate an edge.
//  out is the last stage; it is a square wave with period 2*STAGES*delay_eff clocks while enabled.
//  Sits under the PUF/TRNG wrappers, which count out edges.
// PARAMETERS
//  STAGES  3  number of inverter stages; must be odd and >=3 (elaboration error otherwise)
//  DLY_W   6  width of the delay input and of each per-stage counter
// PORTS
//  clk     in   1      system clock; single clock domain, all state on rising edge
//  rst     in   1      synchronous reset, active-low (0 = reset)
//  enable  in   1      1 = ring runs; 0 = ring held in idle pattern (NAND-gate enable)
//  delay   in   DLY_W  per-stage propagation delay in clock cycles; 0 treated as 1
//  out     out  1      oscillator output = stage[STAGES-1]
// BEHAVIOUR
//  - State
//    - Stage bits s[0..STAGES-1].
//    - One DLY_W-bit counter cnt[k] per stage.
//    - delay_eff = (delay==0) ? 1 : delay, evaluated combinationally every cycle (not latched).
//  - Idle pattern
//    - s[k] = k[0] (0,1,0,...), so s[STAGES-1] = 0.
//    - All cnt = 0.
//  - Reset and enable priority (synchronous, at posedge clk)
//    - rst==0: load the idle pattern. out = 0 the cycle after. Reset has priority over enable.
//    - rst==1 and enable==0: load the idle pattern as well. out stays 0 while disabled.
//  - Stage k input
//    - in[k] = ~s[k-1]; in[0] = ~s[STAGES-1].
//    - Stage k is pending when in[k] != s[k].
//    - In the idle pattern only stage 0 is pending, so exactly one edge circulates.
//  - Per-stage update, each posedge with rst==1 and enable==1:
//    - not pending: cnt[k] <= 0
//    - pending and cnt[k] >= delay_eff-1: s[k] <= in[k]; cnt[k] <= 0
//    - pending otherwise: cnt[k] <= cnt[k]+1
//  - Timing
//    - Each stage flips exactly delay_eff edges after it becomes pending. With delay=1 it flips on the first edge.
//    - A stage becomes pending the edge after its predecessor flips.
//    - Edge N = the Nth posedge with rst==1 and enable==1, counted from the idle pattern.
//    - First out rise at edge STAGES*delay_eff.
//    - After that, out toggles every STAGES*delay_eff edges.
//    - Duty cycle is exactly 50%.
//  - delay changed mid-run
//    - Takes effect immediately on pending counters.
//    - If cnt[k] is already >= new delay_eff-1, the stage flips on the next edge.
//    - No glitches: out changes at most once per clock.
//  - enable dropped mid-run: next edge loads the idle pattern (out=0). Re-enable restarts from edge 1.
//  - out is a registered output; no combinational path from any input to out.
//  - Counter width DLY_W holds up to 63; delay_eff-1 never overflows cnt.
// TESTING
//  1. rst=0 for 2 clks, enable=1, delay=6 -> out=0 and all cnt=0 after reset.
//  2. Release rst (1), enable=1, delay=6, STAGES=3 -> out rises at edge 18, falls at 36, rises at 54 (period 36).
//  3. delay=0 vs delay=1 -> identical waveform: first rise at edge 3, toggles every 3 edges.
//  4. enable=0 mid-run while out=1 -> out=0 next edge and stays 0.
//     Then enable=1 -> first rise 18 edges later.
//  5. delay 6->2 while stage counter=4 -> that stage flips next edge; subsequent toggles every 6 edges.
//  6. rst=0 asserted with enable=1 mid-oscillation -> out=0 next edge; resumes with first rise at edge 18 after release.

Source files
------------

// File: rtl/ring_osc_i.sv
// Clock-driven gated ring oscillator. An odd number of inverter stages pass one edge around the ring.
// Each stage waits a programmable number of clocks before it takes the new value.
module ring_osc_i #(
  parameter int STAGES = 3,
  parameter int DLY_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DLY_W-1:0] delay,
  output logic             out
);

  if ((STAGES < 3) || ((STAGES % 2) == 0)) begin : g_bad_stages
    $error("ring_osc_i: STAGES must be odd and >= 3");
  end

  logic [STAGES-1:0] s;
  logic [STAGES-1:0] in_k;
  logic [DLY_W-1:0]  cnt [STAGES];
  logic [DLY_W-1:0]  dly_eff;
  logic [DLY_W-1:0]  dly_term;

  assign dly_eff  = (delay == '0) ? DLY_W'(1) : delay;
  assign dly_term = dly_eff - DLY_W'(1);

  // Stage k is driven by the inverse of stage k-1, and stage 0 by the last stage.
  assign in_k = ~{s[STAGES-2:0], s[STAGES-1]};

  // The idle pattern 0,1,0,... leaves only stage 0 pending, so exactly one edge
  // circulates after release. Disable shares the reset path, as a NAND-gated ring would.
  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      for (int k = 0; k < STAGES; k++) begin
        s[k]   <= 1'(k % 2);
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (in_k[k] == s[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] >= dly_term) begin
          s[k]   <= in_k[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + DLY_W'(1);
        end
      end
    end
  end

  assign out = s[STAGES-1];

endmodule

// File: tb/tb_ring_osc_i.sv
// Directed bench for ring_osc_i (STAGES=3). The stimulus queues the expected out for every
// clock edge it issues, and a negedge monitor pops each entry and compares it with out.
module tb_ring_osc_i;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [5:0] delay;
  logic       out;

  typedef struct packed {
    logic        val;
    logic [7:0]  phase;
    logic [15:0] n;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  ring_osc_i #(.STAGES(3), .DLY_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .delay  (delay),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (out !== e.val) begin
        bad++;
        $display("FAIL out phase=%0d edge=%0d: got %b want %b", e.phase, e.n, out, e.val);
      end
    end
  end

  task automatic tick(input logic e, input logic [7:0] ph, input logic [15:0] n);
    exp_t x;
    @(posedge clk);
    x.val = e;
    x.phase = ph;
    x.n = n;
    sb.push_back(x);
    #1;
  endtask

  // Free-running from idle: out after edge N is 1 when floor(N / (3*deff)) is odd.
  task automatic run_free(input int n, input int deff, input logic [7:0] ph);
    for (int i = 1; i <= n; i++) tick(1'((i / (3 * deff)) % 2), ph, 16'(i));
  endtask

  task automatic check_val(input int got, input int want, input string name);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    enable = 1'b1;
    delay = 6'd6;

    // 1: reset held for two clocks
    tick(1'b0, 8'd1, 16'd1);
    tick(1'b0, 8'd1, 16'd2);
    check_val(int'(dut.cnt[0]), 0, "rst_cnt0");
    check_val(int'(dut.cnt[1]), 0, "rst_cnt1");
    check_val(int'(dut.cnt[2]), 0, "rst_cnt2");

    // 2: delay=6, rises 18, falls 36, rises 54
    rst = 1'b1;
    run_free(56, 6, 8'd2);

    // 3: delay=0 and delay=1 both give a 3-edge half period
    rst = 1'b0;
    tick(1'b0, 8'd3, 16'd0);
    rst = 1'b1;
    delay = 6'd0;
    run_free(13, 1, 8'd3);
    rst = 1'b0;
    tick(1'b0, 8'd4, 16'd0);
    rst = 1'b1;
    delay = 6'd1;
    run_free(13, 1, 8'd4);

    // 4: drop enable while out=1, then restart
    delay = 6'd6;
    enable = 1'b0;
    tick(1'b0, 8'd5, 16'd0);
    enable = 1'b1;
    run_free(20, 6, 8'd5);
    enable = 1'b0;
    for (int i = 1; i <= 5; i++) tick(1'b0, 8'd6, 16'(i));
    enable = 1'b1;
    run_free(19, 6, 8'd7);

    // 5: delay 6->2 when stage 0 counter is 4
    enable = 1'b0;
    tick(1'b0, 8'd8, 16'd0);
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) tick(1'b0, 8'd8, 16'(i));
    check_val(int'(dut.cnt[0]), 4, "cnt0_before_change");
    delay = 6'd2;
    for (int i = 5; i <= 24; i++) begin
      logic e;
      e = ((i >= 9) && (i <= 14)) || (i >= 21);
      tick(e, 8'd9, 16'(i));
    end

    // 6: reset with enable=1 mid-oscillation
    rst = 1'b0;
    delay = 6'd6;
    tick(1'b0, 8'd10, 16'd0);
    tick(1'b0, 8'd10, 16'd0);
    rst = 1'b1;
    run_free(20, 6, 8'd11);

    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
